// File: rtl/pedestrian_crossing_ctrl.sv
// Pedestrian-side crossing controller: debounces the button, requests a red phase
// from the vehicle light, and sequences WALK / flashing DON'T-WALK with safety abort.
module pedestrian_crossing_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int CLEARANCE_CYCLES = 1,
  parameter int WALK_CYCLES      = 3,
  parameter int FLASH_CYCLES     = 2,
  parameter int HOLDOFF_CYCLES   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_raw_i,
  input  logic red_i,
  input  logic amber_i,
  input  logic green_i,
  output logic pedestrian_button_o,
  output logic walk_o,
  output logic dont_walk_o,
  output logic wait_o,
  output logic abort_o
);

  // A zero-length parameter still occupies one cycle.
  localparam int DEB_EFF   = (DEBOUNCE_CYCLES  < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CLEAR_EFF = (CLEARANCE_CYCLES < 1) ? 1 : CLEARANCE_CYCLES;
  localparam int WALK_EFF  = (WALK_CYCLES      < 1) ? 1 : WALK_CYCLES;
  localparam int FLASH_EFF = (FLASH_CYCLES     < 1) ? 1 : FLASH_CYCLES;
  localparam int HOLD_EFF  = (HOLDOFF_CYCLES   < 1) ? 1 : HOLDOFF_CYCLES;

  localparam int MAX_A   = (CLEAR_EFF > WALK_EFF) ? CLEAR_EFF : WALK_EFF;
  localparam int MAX_B   = (FLASH_EFF > HOLD_EFF) ? FLASH_EFF : HOLD_EFF;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DEB_W   = $clog2(DEB_EFF + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CLEAR,
    ST_WALK,
    ST_FLASH,
    ST_HOLDOFF
  } state_t;

  state_t           state;
  logic [1:0]       sync_q;
  logic             deb_level;
  logic             deb_level_q;
  logic [DEB_W-1:0] deb_cnt;
  logic [CNT_W-1:0] cnt;
  logic             stop;
  logic             stop_q;
  logic             enter_walk;

  // Red alone means stop; red+amber and illegal combinations do not.
  assign stop       = red_i & ~amber_i & ~green_i;
  assign enter_walk = (state == ST_CLEAR) && stop && (cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      deb_level   <= 1'b0;
      deb_level_q <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      sync_q      <= {sync_q[0], button_raw_i};
      deb_level_q <= deb_level;
      if (sync_q[1] == deb_level) begin
        deb_cnt <= '0;
      end else if (int'(deb_cnt) >= DEB_EFF - 1) begin
        deb_level <= sync_q[1];
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // The request latch doubles as the wait indicator; a press landing on WALK entry is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_o <= 1'b0;
    end else if (enter_walk) begin
      wait_o <= 1'b0;
    end else if (deb_level && !deb_level_q) begin
      wait_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      stop_q              <= 1'b0;
      pedestrian_button_o <= 1'b0;
      walk_o              <= 1'b0;
      dont_walk_o         <= 1'b1;
      abort_o             <= 1'b0;
    end else begin
      stop_q              <= stop;
      pedestrian_button_o <= 1'b0;
      abort_o             <= 1'b0;
      case (state)
        ST_IDLE: begin
          walk_o      <= 1'b0;
          dont_walk_o <= 1'b1;
          if (wait_o && !red_i) begin
            pedestrian_button_o <= 1'b1;
            state               <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (stop && !stop_q) begin
            cnt   <= CNT_W'(CLEAR_EFF - 1);
            state <= ST_CLEAR;
          end
        end
        ST_CLEAR, ST_WALK, ST_FLASH: begin
          if (!stop) begin
            walk_o      <= 1'b0;
            dont_walk_o <= 1'b1;
            abort_o     <= 1'b1;
            cnt         <= CNT_W'(HOLD_EFF - 1);
            state       <= ST_HOLDOFF;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (state == ST_FLASH) dont_walk_o <= ~dont_walk_o;
          end else if (state == ST_CLEAR) begin
            walk_o      <= 1'b1;
            dont_walk_o <= 1'b0;
            cnt         <= CNT_W'(WALK_EFF - 1);
            state       <= ST_WALK;
          end else if (state == ST_WALK) begin
            walk_o      <= 1'b0;
            dont_walk_o <= 1'b1;
            cnt         <= CNT_W'(FLASH_EFF - 1);
            state       <= ST_FLASH;
          end else begin
            dont_walk_o <= 1'b1;
            cnt         <= CNT_W'(HOLD_EFF - 1);
            state       <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          walk_o      <= 1'b0;
          dont_walk_o <= 1'b1;
          if (cnt == '0) state <= ST_IDLE;
          else cnt <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pedestrian_crossing_ctrl.md
Name: pedestrian_crossing_ctrl

Overview:
- Pedestrian-side end of the vehicle traffic light's pedestrian interface.
- Debounces the physical crossing button and latches the request.
- Issues the single-cycle pedestrian_button request to the vehicle light controller.
- Observes the returned red/amber/green lamp signals and drives the WALK / DON'T-WALK pedestrian lamps, with clearance, flashing and safety abort.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to change the debounced button level
CLEARANCE_CYCLES, 1, all-red cycles after vehicle red before WALK
WALK_CYCLES, 3, cycles WALK is lit
FLASH_CYCLES, 2, cycles of flashing DON'T-WALK after WALK
HOLDOFF_CYCLES, 8, minimum cycles after a crossing ends before a new request is forwarded

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous, active-high reset
button_raw_i  input  1  raw, asynchronous, bouncing pedestrian button
red_i  input  1  vehicle red lamp
amber_i  input  1  vehicle amber lamp
green_i  input  1  vehicle green lamp
pedestrian_button_o  output  1  one-cycle request pulse to the vehicle light controller
walk_o  output  1  WALK lamp
dont_walk_o  output  1  DON'T-WALK lamp
wait_o  output  1  "request registered" indicator
abort_o  output  1  one-cycle pulse when a crossing is cut short

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; all counters=0; synchronizer flops, debounced level and request latch=0.
  - Outputs: walk_o=0, dont_walk_o=1, wait_o=0, pedestrian_button_o=0, abort_o=0.
- All outputs are registered.
- Input path:
  - button_raw_i passes through a 2-flop synchronizer.
  - Debounced level flips only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample resets the debounce count.
  - A rising edge of the debounced level sets the request latch; wait_o = latch.
  - Timing: with a clean press, wait_o rises DEBOUNCE_CYCLES+3 edges after the first edge that samples button_raw_i=1.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
- Stop condition: stop = red_i & ~amber_i & ~green_i. Red+amber is not stop.
- State machine:
  - IDLE: dont_walk_o=1.
    - If latch=1 and red_i=0: assert pedestrian_button_o for exactly one cycle, go to ARMED.
    - If latch=1 and red_i=1: stay in IDLE with no pulse. This avoids re-extending a red phase already in progress.
  - ARMED: wait for a rising edge of stop (stop=1, previous-cycle stop=0). On that edge, load the counter and go to CLEAR.
  - CLEAR: dont_walk_o=1 for CLEARANCE_CYCLES cycles, then go to WALK. The latch clears on entry to WALK.
  - WALK: walk_o=1, dont_walk_o=0 for WALK_CYCLES cycles, then go to FLASH.
  - FLASH: walk_o=0; dont_walk_o toggles every cycle starting at 1, for FLASH_CYCLES cycles, then go to HOLDOFF.
  - HOLDOFF: dont_walk_o=1 for HOLDOFF_CYCLES cycles, then go to IDLE. Presses during HOLDOFF are latched but not forwarded until IDLE.
- Abort:
  - Trigger: stop=0 in any cycle of CLEAR, WALK or FLASH.
  - Next cycle: state=HOLDOFF, walk_o=0, dont_walk_o=1, abort_o=1 for one cycle.
  - The latch is retained if the abort happens in CLEAR. Otherwise it is already clear.
- Boundaries:
  - Multiple presses while the latch is set have no extra effect.
  - A press coinciding with the latch clearing on entry to WALK: clear wins; the press is lost.
  - Never more than one pedestrian_button_o pulse per crossing.
  - Illegal lamp combinations (e.g. green_i & red_i) count as stop=0.
  - Counters are sized $clog2(max+1). A counter value of 0 or parameter=0 is treated as 1 cycle in that state.
  - Reset mid-crossing: lamps return to DON'T-WALK immediately and asynchronously.

Test Plan:
- Reset: assert rst_i during WALK -> same-cycle walk_o=0, dont_walk_o=1; after release state=IDLE, wait_o=0.
- Debounce: 3-cycle raw pulse -> wait_o stays 0. Raw held high 10 cycles -> wait_o rises at edge 7 (DEBOUNCE_CYCLES+3).
- Full crossing during green:
  - Press -> one-cycle pedestrian_button_o after wait_o.
  - Drive stop rising edge -> 1 cycle CLEAR, walk_o=1 for 3 cycles (wait_o falls with walk), dont_walk_o pattern 1,0 in FLASH.
  - Then 8 cycles HOLDOFF, then IDLE.
- Press while red_i=1 -> no pulse until red_i=0. Pulse appears the cycle after red_i falls (latch already set).
- Abort: set amber_i=1 on 2nd WALK cycle -> next cycle walk_o=0, dont_walk_o=1, abort_o=1 for one cycle, state HOLDOFF.
- Press during HOLDOFF -> wait_o=1, no pulse until HOLDOFF expires, then exactly one pedestrian_button_o.
